// File: rtl/fp_neg2_scale.sv
// Streaming fp32 scaler: out = in * -2 (NEGATE=1) or * +2 (NEGATE=0), 2-stage valid/ready pipe.
// Optional FP_NEG2_DENORM_EN: scale denormals exactly; otherwise they flush to signed zero.
module fp_neg2_scale #(
    parameter bit          NEGATE = 1'b1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_nan
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORM,
        CLS_OVF,
        CLS_INF,
        CLS_NAN
    } cls_e;

    logic             s1_v_q, s1_v_d;
    logic             s1_s_q, s1_s_d;
    logic [7:0]       s1_e_q, s1_e_d;
    logic [22:0]      s1_m_q, s1_m_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    cls_e             s1_cls_q, s1_cls_d;

    logic             s2_v_q, s2_v_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_nan_q, s2_nan_d;

    logic             s2_adv;
    cls_e             in_cls;
    logic [31:0]      res;
    logic [7:0]       e_inc;

    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;

    always_comb begin
        in_cls = CLS_NORM;
        if (in_data[30:23] == 8'd0) begin
            in_cls = (in_data[22:0] == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (in_data[30:23] == 8'd255) begin
            in_cls = (in_data[22:0] == '0) ? CLS_INF : CLS_NAN;
        end else if (in_data[30:23] == 8'd254) begin
            in_cls = CLS_OVF;
        end
    end

    assign e_inc = s1_e_q + 8'd1;

    always_comb begin
        res = {s1_s_q, 31'h0};
        unique case (s1_cls_q)
            CLS_ZERO:   res = {s1_s_q, 8'h00, 23'h0};
`ifdef FP_NEG2_DENORM_EN
            // Doubling a denormal is a left shift; the top mantissa bit lands in the exponent LSB.
            CLS_DENORM: res = {s1_s_q, 7'h0, s1_m_q[22], s1_m_q[21:0], 1'b0};
`else
            CLS_DENORM: res = {s1_s_q, 31'h0};
`endif
            CLS_NORM:   res = {s1_s_q, e_inc, s1_m_q};
            CLS_OVF:    res = {s1_s_q, 8'hFF, 23'h0};
            CLS_INF:    res = {s1_s_q, 8'hFF, 23'h0};
            CLS_NAN:    res = {s1_s_q, 8'hFF, s1_m_q | 23'h400000};
            default:    res = {s1_s_q, 31'h0};
        endcase
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_s_d   = s1_s_q;
        s1_e_d   = s1_e_q;
        s1_m_d   = s1_m_q;
        s1_tag_d = s1_tag_q;
        s1_cls_d = s1_cls_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_s_d   = in_data[31] ^ NEGATE;
                s1_e_d   = in_data[30:23];
                s1_m_d   = in_data[22:0];
                s1_tag_d = in_tag;
                s1_cls_d = in_cls;
            end
        end

        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        s2_ovf_d  = s2_ovf_q;
        s2_nan_d  = s2_nan_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = res;
                s2_tag_d  = s1_tag_q;
                s2_ovf_d  = (s1_cls_q == CLS_OVF);
                s2_nan_d  = (s1_cls_q == CLS_NAN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_s_q    <= 1'b0;
            s1_e_q    <= '0;
            s1_m_q    <= '0;
            s1_tag_q  <= '0;
            s1_cls_q  <= CLS_ZERO;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
            s2_ovf_q  <= 1'b0;
            s2_nan_q  <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_s_q    <= s1_s_d;
            s1_e_q    <= s1_e_d;
            s1_m_q    <= s1_m_d;
            s1_tag_q  <= s1_tag_d;
            s1_cls_q  <= s1_cls_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
            s2_ovf_q  <= s2_ovf_d;
            s2_nan_q  <= s2_nan_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_ovf   = s2_ovf_q;
    assign out_nan   = s2_nan_q;

endmodule

// File: tb/tb_fp_neg2_scale.sv
// Bench for fp_neg2_scale: a *-2 instance and a *+2 instance share one input stream.
// Expected results come from a magnitude-based fp32 doubling model plus literal vectors.
module tb_fp_neg2_scale;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready_p;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic        out_valid, out_valid_p;
    logic [31:0] out_data, out_data_p;
    logic [3:0]  out_tag, out_tag_p;
    logic        out_ovf, out_ovf_p, out_nan, out_nan_p;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    typedef struct {
        logic [31:0] dn;
        logic [31:0] dp;
        logic [3:0]  tag;
        logic        ovf;
        logic        nan;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_tag[$];
    int unsigned got_cyc[$];

    logic        stab_pend = 1'b0;
    logic [31:0] hv_data;
    logic [3:0]  hv_tag;
    logic        hv_ovf, hv_nan;

    always #5 clk = ~clk;

    fp_neg2_scale #(.NEGATE(1'b1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_ovf(out_ovf), .out_nan(out_nan)
    );

    fp_neg2_scale #(.NEGATE(1'b0), .TAG_W(4)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p), .out_tag(out_tag_p),
        .out_ovf(out_ovf_p), .out_nan(out_nan_p)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Doubling on the 31-bit magnitude: adding one ULP of exponent for normals, shifting for denormals.
    function automatic exp_t model(input logic [31:0] x, input logic [3:0] tag);
        exp_t        r;
        logic [30:0] mag;
        logic [30:0] rmag;
        mag   = x[30:0];
        r.tag = tag;
        r.ovf = 1'b0;
        r.nan = 1'b0;
        if (mag > 31'h7F800000) begin
            rmag  = mag | 31'h00400000;
            r.nan = 1'b1;
        end else if (mag == 31'h7F800000) begin
            rmag = 31'h7F800000;
        end else if (mag >= 31'h7F000000) begin
            rmag  = 31'h7F800000;
            r.ovf = 1'b1;
        end else if (mag < 31'h00800000) begin
`ifdef FP_NEG2_DENORM_EN
            rmag = mag << 1;
`else
            rmag = '0;
`endif
        end else begin
            rmag = mag + 31'h00800000;
        end
        r.dn = {~x[31], rmag};
        r.dp = {x[31], rmag};
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            stab_pend = 1'b0;
        end else begin
            if (stab_pend) begin
                chk("hold_valid", {31'h0, out_valid}, 32'h1);
                chk("hold_data", out_data, hv_data);
                chk("hold_tag", {28'h0, out_tag}, {28'h0, hv_tag});
                chk("hold_flags", {30'h0, out_ovf, out_nan}, {30'h0, hv_ovf, hv_nan});
            end
            chk("ready_match", {31'h0, in_ready_p}, {31'h0, in_ready});
            chk("valid_match", {31'h0, out_valid_p}, {31'h0, out_valid});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_data, 32'hDEADBEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("neg_data", out_data, e.dn);
                    chk("pos_data", out_data_p, e.dp);
                    chk("tag", {28'h0, out_tag}, {28'h0, e.tag});
                    chk("tag_p", {28'h0, out_tag_p}, {28'h0, e.tag});
                    chk("flags", {30'h0, out_ovf, out_nan}, {30'h0, e.ovf, e.nan});
                    chk("flags_p", {30'h0, out_ovf_p, out_nan_p}, {30'h0, e.ovf, e.nan});
                end
                got_data.push_back(out_data);
                got_tag.push_back(out_tag);
                got_cyc.push_back(cyc);
            end
            stab_pend = out_valid && !out_ready;
            hv_data   = out_data;
            hv_tag    = out_tag;
            hv_ovf    = out_ovf;
            hv_nan    = out_nan;
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_tag));
        end
    end

    // Called at posedge+1; holds in_valid until accepted, returns at posedge+1 after the transfer.
    task automatic send(input logic [31:0] d, input logic [3:0] t);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] d, input logic [3:0] t, input logic [31:0] en,
                           input logic [31:0] ep, input logic ovf, input logic nan);
        send(d, t);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'h0, out_valid}, 32'h1);
        chk("lit_neg", out_data, en);
        chk("lit_pos", out_data_p, ep);
        chk("lit_tag", {28'h0, out_tag}, {28'h0, t});
        chk("lit_flags", {30'h0, out_ovf, out_nan}, {30'h0, ovf, nan});
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_tag_flags", {26'h0, out_tag, out_ovf, out_nan}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        run_one(32'h3F800000, 4'd3, 32'hC0000000, 32'h40000000, 1'b0, 1'b0);
        run_one(32'h7F000000, 4'd5, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0);
        run_one(32'hFF800000, 4'd6, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0);
        run_one(32'h7FA00001, 4'd7, 32'hFFE00001, 32'h7FE00001, 1'b0, 1'b1);
        run_one(32'h80000000, 4'd8, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_one(32'h00000000, 4'd9, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        run_one(32'h7EFFFFFF, 4'd10, 32'hFF7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0);
`ifdef FP_NEG2_DENORM_EN
        run_one(32'h00400000, 4'd11, 32'h80800000, 32'h00800000, 1'b0, 1'b0);
        run_one(32'h80000001, 4'd12, 32'h00000002, 32'h80000002, 1'b0, 1'b0);
`else
        run_one(32'h00400000, 4'd11, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        run_one(32'h80000001, 4'd12, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
`endif

        // Backpressure: three back-to-back samples with the output stalled.
        out_ready = 1'b0;
        base      = got_data.size();
        send(32'h3F800000, 4'd1);
        send(32'h40000000, 4'd2);
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        in_data  = 32'h40400000;
        in_tag   = 4'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_hold_data", out_data, 32'hC0000000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h40400000, 4'd4);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_count", got_data.size() - base, 32'd3);
        if (got_data.size() >= base + 3) begin
            chk("bp_out0", got_data[base], 32'hC0000000);
            chk("bp_out1", got_data[base+1], 32'hC0800000);
            chk("bp_out2", got_data[base+2], 32'hC0C00000);
            chk("bp_tags", {20'h0, got_tag[base], got_tag[base+1], got_tag[base+2]}, 32'h124);
        end

        // Full-rate stream of random finite normals.
        base = got_data.size();
        for (int i = 0; i < 100; i++) begin
            in_data  = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 253)), 23'($urandom)};
            in_tag   = 4'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_count", got_data.size() - base, 32'd100);
        if (got_data.size() >= base + 100)
            chk("stream_no_bubbles", got_cyc[base+99] - got_cyc[base], 32'd99);

        // Reset with two samples in flight.
        out_ready = 1'b0;
        send(32'h3F800000, 4'd13);
        send(32'h40000000, 4'd14);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        base      = got_data.size();
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", got_data.size() - base, 32'd0);

        run_one(32'h40400000, 4'd15, 32'hC0C00000, 32'h40C00000, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
